// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU interface.
// Takes one operation at a time on a valid/ready request channel, drives the
// ALU for a single cycle, waits out the ALU result and zero-flag latency and
// returns the captured values on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3,
  parameter int RES_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  // response channel
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [15:0]       op_count,
  // ALU side
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(4);

  // Wait counter runs RES_LAT-1 down to 0; the zero cycle is the capture cycle.
  localparam int              CNT_W     = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [CNT_W-1:0] WCNT_INIT = CNT_W'(RES_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ZFLAG = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_in1;
  logic [DATA_W-1:0]   r_in2;
  logic [CNT_W-1:0]    r_wcnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_zero;
  logic                r_err;
  logic [15:0]         r_cnt;

  logic                w_accept;
  logic                w_legal;
  logic                w_wait_done;
  logic                w_resp_hs;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_legal     = (req_op == OP_ADD) || (req_op == OP_SUB) ||
                       (req_op == OP_SHL) || (req_op == OP_SHR);
  assign w_wait_done = (r_wcnt == '0);
  assign w_resp_hs   = (r_state == S_RESP) && resp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: illegal ops skip the ALU entirely and go straight to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_wait_done) w_next = S_ZFLAG;
      S_ZFLAG: w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; the opcode reaches the ALU only during ISSUE, so
  // reset or any other state forces the ALU to hold.
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    alu_op     = (r_state == S_ISSUE) ? r_op : '0;
  end

  // Operand latch, latency counter, result/zero capture and completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_in1  <= '0;
      r_in2  <= '0;
      r_wcnt <= '0;
      r_data <= '0;
      r_zero <= 1'b0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_legal) begin
            r_op  <= req_op;
            r_in1 <= req_a;
            r_in2 <= req_b;
          end else if (w_accept) begin
            r_err  <= 1'b1;
            r_data <= '0;
            r_zero <= 1'b0;
          end
        end
        S_ISSUE: r_wcnt <= WCNT_INIT;
        S_WAIT: begin
          if (w_wait_done) r_data <= alu_out;
          else             r_wcnt <= r_wcnt - 1'b1;
        end
        S_ZFLAG: begin
          r_zero <= alu_z;
          r_cnt  <= r_cnt + 16'd1;
        end
        S_RESP: if (w_resp_hs) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign resp_data = r_data;
  assign resp_zero = r_zero;
  assign resp_err  = r_err;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural ALU sits on the ALU port,
// expected results come from an arithmetic reference of the opcode rules.
module tb_alu_issue_ctrl;

  localparam int DW      = 16;
  localparam int OW      = 3;
  localparam int RES_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [OW-1:0] req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_zero;
  logic          resp_err;
  logic [15:0]   op_count;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [DW-1:0] alu_out = 16'hBEEF;
  logic          alu_z   = 1'b0;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int issue_cycles = 0;

  alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_err(resp_err), .op_count(op_count),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: registered result, zero flag registered from alu_out.
  always @(posedge clk) begin
    case (alu_op)
      3'd1: alu_out <= alu_in1 + alu_in2;
      3'd2: alu_out <= alu_in2 - alu_in1;
      3'd3: alu_out <= alu_in1 << alu_in2;
      3'd4: alu_out <= alu_in1 >> alu_in2;
      default: ;
    endcase
    alu_z <= (alu_out == '0);
  end

  // Count cycles the ALU is commanded to do work.
  always @(posedge clk) if (alu_op != '0) issue_cycles <= issue_cycles + 1;

  // Arithmetic reference of the opcode rules.
  function automatic logic [DW-1:0] ref_res(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint la, lb, r;
    la = longint'(a);
    lb = longint'(b);
    case (op)
      3'd1: r = (la + lb) % 65536;
      3'd2: r = (lb - la + 65536) % 65536;
      3'd3: r = (lb >= 16) ? 0 : (la * (longint'(2) ** lb)) % 65536;
      3'd4: r = (lb >= 16) ? 0 : la / (longint'(2) ** lb);
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input int bp);
    logic [DW-1:0] ed;
    logic          ez, ee;
    bit            legal;
    int            n0, k;
    legal = (op >= 3'd1) && (op <= 3'd4);
    ed = legal ? ref_res(op, a, b) : '0;
    ez = legal && (ed == '0);
    ee = !legal;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    n0 = issue_cycles;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OW'($urandom); req_a = DW'($urandom); req_b = DW'($urandom);
    if (legal) begin
      check("issue_op",  {29'd0, alu_op}, {29'd0, op});
      check("issue_in1", {16'd0, alu_in1}, {16'd0, a});
      check("issue_in2", {16'd0, alu_in2}, {16'd0, b});
      check("busy_ready", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < RES_LAT + 2; i++) begin
        check("early_valid", {31'd0, resp_valid}, 32'd0);
        if (i == 1) begin
          check("hold_op",  {29'd0, alu_op}, 32'd0);
          check("hold_in1", {16'd0, alu_in1}, {16'd0, a});
        end
        @(posedge clk); #1;
      end
      exp_cnt = (exp_cnt + 1) % 65536;
    end else begin
      check("illegal_op", {29'd0, alu_op}, 32'd0);
    end
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data",  {16'd0, resp_data}, {16'd0, ed});
    check("resp_zero",  {31'd0, resp_zero}, {31'd0, ez});
    check("resp_err",   {31'd0, resp_err}, {31'd0, ee});
    check("op_count",   {16'd0, op_count}, exp_cnt);
    // Backpressure with a competing request that must not be taken.
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_op = 3'd1;
      @(posedge clk); #1;
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_data",  {16'd0, resp_data}, {16'd0, ed});
      check("bp_zero",  {31'd0, resp_zero}, {31'd0, ez});
      check("bp_err",   {31'd0, resp_err}, {31'd0, ee});
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      check("bp_aluop", {29'd0, alu_op}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("hs_valid", {31'd0, resp_valid}, 32'd0);
    check("hs_ready", {31'd0, req_ready}, 32'd1);
    check("hs_err",   {31'd0, resp_err}, 32'd0);
    check("alu_issues", issue_cycles - n0, legal ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] rop;
    logic [DW-1:0] ra, rb;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_data",  {16'd0, resp_data}, 32'd0);
    check("rst_zero",  {31'd0, resp_zero}, 32'd0);
    check("rst_err",   {31'd0, resp_err}, 32'd0);
    check("rst_cnt",   {16'd0, op_count}, 32'd0);
    check("rst_aluop", {29'd0, alu_op}, 32'd0);
    check("rst_in1",   {16'd0, alu_in1}, 32'd0);
    check("rst_in2",   {16'd0, alu_in2}, 32'd0);
    rst = 1'b0;

    do_op(3'd1, 16'd5, 16'd3, 0);
    do_op(3'd2, 16'd7, 16'd7, 0);
    do_op(3'd2, 16'd3, 16'd10, 0);
    do_op(3'd3, 16'd1, 16'd4, 0);
    do_op(3'd4, 16'h8000, 16'd15, 0);
    do_op(3'd3, 16'd1, 16'd16, 0);
    do_op(3'd1, 16'hFFFF, 16'd2, 5);
    do_op(3'd6, 16'd1, 16'd1, 2);
    do_op(3'd0, 16'd9, 16'd9, 0);

    // Reset during the WAIT cycle discards the in-flight op.
    req_valid = 1'b1; req_op = 3'd1; req_a = 16'd2; req_b = 16'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_cnt",   {16'd0, op_count}, 32'd0);
    check("mid_rst_aluop", {29'd0, alu_op}, 32'd0);
    check("mid_rst_in1",   {16'd0, alu_in1}, 32'd0);
    check("mid_rst_data",  {16'd0, resp_data}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_novalid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    exp_cnt = 0;
    do_op(3'd1, 16'd1, 16'd1, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      rop = OW'($urandom_range(0, 7));
      ra  = DW'($urandom);
      rb  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      if ($urandom_range(0, 5) == 0) rb = ra;
      do_op(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
